regfile_wb_ctrl: RTL and testbench

- Write-back controller and hazard scoreboard for the 32x32 register file.
- Arbitrates two write-back requesters onto the single register-file write port: the ALU result path and the load/memory result path.
- Mem wins by fixed priority, with a starvation guard for the ALU.
- Tracks destination registers with pending writes and raises a stall to decode when a source operand is still in flight.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_wb_ctrl_if.sv | 30 +++
 rtl/wb_arbiter.sv | 46 ++++
 rtl/regfile_wb_ctrl.sv | 101 ++++++++++
 tb/tb_regfile_wb_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back controller:
// widths, register-file geometry and the write-back request bundle.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // One write-back request as seen by the arbiter
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Write-back request channels from the ALU and the load path.
// The requesters are the master side; the write-back controller is the slave side.
interface regfile_wb_ctrl_if;
    import regfile_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready
    );

endinterface

// File: rtl/wb_arbiter.sv
// Two-way write-back arbiter. The load path wins by fixed priority, but an
// ALU request that has lost STARVE_MAX consecutive cycles is forced through.
module wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic    clk,
    input  logic    rst,
    input  wb_req_t alu_req,
    input  wb_req_t mem_req,
    output logic    alu_grant,
    output logic    mem_grant,
    output wb_req_t win_req
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_alu;

    // Grant decision and winner mux; nothing is granted while reset is asserted
    always_comb begin
        force_alu = alu_req.valid && (starve_cnt == CNT_MAX);
        mem_grant = !rst && mem_req.valid && !force_alu;
        alu_grant = !rst && alu_req.valid && (!mem_req.valid || force_alu);

        win_req       = '0;
        win_req.valid = alu_grant || mem_grant;
        win_req.addr  = mem_grant ? mem_req.addr : alu_req.addr;
        win_req.data  = mem_grant ? mem_req.data : alu_req.data;
    end

    // Saturating count of consecutive cycles in which a waiting ALU request lost
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!alu_req.valid || alu_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller and hazard scoreboard for the 32x32 register file.
// Arbitrates ALU and load write-backs onto the single write port, tracks
// registers with writes in flight and stalls decode on a pending source.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_ctrl_if.slave    wb,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic                stall,
    output logic                w_enable,
    output logic [ADDR_W-1:0]   w_address,
    output logic [DATA_W-1:0]   w_data,
    output logic [NUM_REGS-1:0] busy_vec
);

    wb_req_t             alu_req;
    wb_req_t             mem_req;
    wb_req_t             win_req;
    logic                alu_grant;
    logic                mem_grant;
    logic [NUM_REGS-1:0] busy_next;
    logic                win_nonzero;

    // Repack the interface channels into request structs for the arbiter
    always_comb begin
        alu_req       = '0;
        alu_req.valid = wb.alu_valid;
        alu_req.addr  = wb.alu_addr;
        alu_req.data  = wb.alu_data;
        mem_req       = '0;
        mem_req.valid = wb.mem_valid;
        mem_req.addr  = wb.mem_addr;
        mem_req.data  = wb.mem_data;
    end

    wb_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arbiter (
        .clk       (clk),
        .rst       (rst),
        .alu_req   (alu_req),
        .mem_req   (mem_req),
        .alu_grant (alu_grant),
        .mem_grant (mem_grant),
        .win_req   (win_req)
    );

    assign wb.alu_ready = alu_grant;
    assign wb.mem_ready = mem_grant;
    assign win_nonzero  = win_req.valid && (win_req.addr != REG_ZERO);

    // Register-file write port: one cycle after the transfer, $0 writes are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            w_enable  <= 1'b0;
            w_address <= '0;
            w_data    <= '0;
        end else if (win_nonzero) begin
            w_enable  <= 1'b1;
            w_address <= win_req.addr;
            w_data    <= win_req.data;
        end else begin
            w_enable  <= 1'b0;
        end
    end

    // Next scoreboard state: clear on write-back, then set on issue so a newer producer wins
    always_comb begin
        busy_next = busy_vec;
        if (win_nonzero) begin
            busy_next[win_req.addr] = 1'b0;
        end
        if (issue_valid && (issue_addr != REG_ZERO)) begin
            busy_next[issue_addr] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
        end
    end

    // Stall while either source operand still has a write in flight
    always_comb begin
        stall = ((rd_addr1 != REG_ZERO) && busy_vec[rd_addr1]) ||
                ((rd_addr2 != REG_ZERO) && busy_vec[rd_addr2]);
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl. Expected write-port
// contents are queued when a request is driven and compared one edge later.
module tb_regfile_wb_ctrl;
    import regfile_pkg::*;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic                clk;
    logic                rst;
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_addr;
    logic [ADDR_W-1:0]   rd_addr1;
    logic [ADDR_W-1:0]   rd_addr2;
    logic                stall;
    logic                w_enable;
    logic [ADDR_W-1:0]   w_address;
    logic [DATA_W-1:0]   w_data;
    logic [NUM_REGS-1:0] busy_vec;

    int compared   = 0;
    int mismatched = 0;

    wr_t                 exp_q[$];
    logic [NUM_REGS-1:0] exp_busy;
    logic [ADDR_W-1:0]   last_addr;
    logic [DATA_W-1:0]   last_data;

    regfile_wb_ctrl_if wb_if ();

    regfile_wb_ctrl #(
        .STARVE_MAX (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (wb_if.slave),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .stall       (stall),
        .w_enable    (w_enable),
        .w_address   (w_address),
        .w_data      (w_data),
        .busy_vec    (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input string what,
                               input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                                 input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                                 input logic iv, input logic [ADDR_W-1:0] ia,
                                 input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
        wb_if.alu_valid = av;
        wb_if.alu_addr  = aa;
        wb_if.alu_data  = ad;
        wb_if.mem_valid = mv;
        wb_if.mem_addr  = ma;
        wb_if.mem_data  = md;
        issue_valid     = iv;
        issue_addr      = ia;
        rd_addr1        = r1;
        rd_addr2        = r2;
    endtask

    // One clock: check grants/stall mid-cycle, queue the expected write, check after the edge
    task automatic tick(input string tag, input logic e_alu, input logic e_mem, input logic e_stall);
        wr_t w;
        wr_t got;
        logic [ADDR_W-1:0] t_addr;
        logic [DATA_W-1:0] t_data;
        logic              t_valid;
        @(negedge clk);
        checkOutput(tag, "alu_ready", 32'(wb_if.alu_ready), 32'(e_alu));
        checkOutput(tag, "mem_ready", 32'(wb_if.mem_ready), 32'(e_mem));
        checkOutput(tag, "stall",     32'(stall),           32'(e_stall));
        t_valid = e_alu || e_mem;
        t_addr  = e_mem ? wb_if.mem_addr : wb_if.alu_addr;
        t_data  = e_mem ? wb_if.mem_data : wb_if.alu_data;
        if (rst) begin
            w         = '0;
            exp_busy  = '0;
            last_addr = '0;
            last_data = '0;
        end else begin
            if (t_valid && t_addr != 0) begin
                last_addr        = t_addr;
                last_data        = t_data;
                exp_busy[t_addr] = 1'b0;
                w.en             = 1'b1;
            end else begin
                w.en = 1'b0;
            end
            w.addr = last_addr;
            w.data = last_data;
            if (issue_valid && issue_addr != 0) exp_busy[issue_addr] = 1'b1;
            exp_busy[0] = 1'b0;
        end
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        checkOutput(tag, "w_enable",  32'(w_enable),  32'(got.en));
        checkOutput(tag, "w_address", 32'(w_address), 32'(got.addr));
        checkOutput(tag, "w_data",    w_data,         got.data);
        checkOutput(tag, "busy_vec",  busy_vec,       exp_busy);
    endtask

    initial begin
        exp_busy  = '0;
        last_addr = '0;
        last_data = '0;

        // Reset held two cycles with both requesters valid: nothing granted
        rst = 1'b1;
        applyStimulus(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 0, 0, 0);
        tick("rst_a", 0, 0, 0);
        tick("rst_b", 0, 0, 0);

        // Single load write-back, then idle so w_enable drops and address/data hold
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
        tick("single_wr", 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("single_idle", 0, 0, 0);

        // Continuous contention: mem x3, ALU forced, mem x3, ALU forced
        applyStimulus(1, 5'd11, 32'hAAAA0011, 1, 5'd10, 32'hBBBB0010, 0, 0, 0, 0);
        tick("cont1", 0, 1, 0);
        tick("cont2", 0, 1, 0);
        tick("cont3", 0, 1, 0);
        tick("cont4", 1, 0, 0);
        tick("cont5", 0, 1, 0);
        tick("cont6", 0, 1, 0);
        tick("cont7", 0, 1, 0);
        tick("cont8", 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("cont_idle", 0, 0, 0);

        // Register zero: write accepted but dropped, issue to $0 never marks busy
        applyStimulus(1, 5'd0, 32'h1234, 0, 0, 0, 1, 5'd0, 0, 0);
        tick("zero_reg", 1, 0, 0);

        // Hazard on operand 1: stall holds through the clearing cycle, drops after
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
        tick("iss7", 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
        tick("haz_wait", 0, 0, 1);
        applyStimulus(1, 5'd7, 32'h77, 0, 0, 0, 0, 0, 5'd7, 0);
        tick("haz_wb", 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
        tick("haz_clear", 0, 0, 0);

        // Hazard on operand 2, with an independent issue on the clearing edge
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 0);
        tick("iss12", 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd12);
        tick("haz_rd2", 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 5'd12, 32'hC0FFEE12, 1, 5'd13, 0, 5'd12);
        tick("rd2_wb", 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd13, 5'd12);
        tick("rd2_after", 0, 0, 1);

        // Set/clear collision on register 9 that is already busy: set wins
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);
        tick("iss9", 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5'd9, 32'h99, 1, 5'd9, 0, 0);
        tick("collide", 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9);
        tick("collide_after", 0, 0, 1);

        // Reset mid-contention: in-flight write lands, busy and starvation clear
        applyStimulus(1, 5'd11, 32'h5511, 1, 5'd10, 32'h6610, 0, 0, 0, 0);
        tick("pre_rst1", 0, 1, 0);
        tick("pre_rst2", 0, 1, 0);
        rst = 1'b1;
        tick("mid_rst", 0, 0, 0);
        rst = 1'b0;
        tick("post_rst1", 0, 1, 0);
        tick("post_rst2", 0, 1, 0);
        tick("post_rst3", 0, 1, 0);
        tick("post_rst4", 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("final_idle", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
